// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//   Shared definitions for the immediate extender.
//   - ext_mode_e  : extension mode encoding driven on in_mode.
//   - EXT_MAX_W   : widest datapath the extension function supports.
//   - imm_extend(): width-generic extension. It is used by the RTL and can
//                   also serve as a reference model.
//
//   The function works on EXT_MAX_W-bit vectors so that one definition serves
//   any (IN_W, OUT_W) pair. Callers pass the immediate zero-extended to
//   EXT_MAX_W and take the low OUT_W bits of the result.
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_UPPER = 2'd2,
    EXT_BYTE  = 2'd3
  } ext_mode_e;

  localparam int EXT_MAX_W = 64;

  // Extend the low in_w bits of data to out_w bits according to mode.
  // Bits at and above out_w are always returned as zero.
  function automatic logic [EXT_MAX_W-1:0] imm_extend(
    input logic [EXT_MAX_W-1:0] data,
    input ext_mode_e            mode,
    input int unsigned          in_w,
    input int unsigned          out_w
  );
    logic [EXT_MAX_W-1:0]        mask;
    logic [EXT_MAX_W-1:0]        field;
    logic signed [EXT_MAX_W-1:0] top_aligned;
    logic [EXT_MAX_W-1:0]        r;

    mask  = {EXT_MAX_W{1'b1}} >> (EXT_MAX_W - out_w);
    // Isolate the immediate field, discarding anything above in_w.
    field = (data << (EXT_MAX_W - in_w)) >> (EXT_MAX_W - in_w);
    // Field moved to the top so an arithmetic shift can replicate its MSB.
    top_aligned = data << (EXT_MAX_W - in_w);

    case (mode)
      EXT_SIGN:  r = top_aligned >>> (EXT_MAX_W - in_w);
      EXT_ZERO:  r = field;
      EXT_UPPER: r = field << (out_w - in_w);
      EXT_BYTE:  r = {{(EXT_MAX_W-8){data[7]}}, data[7:0]};
      default:   r = '0;
    endcase

    return r & mask;
  endfunction

endpackage

// File: rtl/mips_sync_fifo.sv
// ---------------------------------------------------------------------------
// mips_sync_fifo
//   Single-clock FIFO with valid/ready on both sides and a synchronous clear.
//
//   Ports
//     clk_i      : clock, all state changes on the rising edge
//     rst_ni     : asynchronous active-low reset (pointers and count only)
//     flush_i    : synchronous clear; overrides push and pop that cycle
//     wr_valid_i : write request
//     wr_ready_o : FIFO has room (count != DEPTH)
//     wr_data_i  : write data
//     rd_valid_o : head entry is valid (count != 0)
//     rd_ready_i : consumer takes the head this cycle
//     rd_data_o  : head entry, read straight from storage
//     count_o    : occupied entries
//
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module mips_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push;
  logic pop;

  // Ready/valid depend only on registered count, so there is no
  // combinational path from rd_ready_i to wr_ready_o.
  assign wr_ready_o = (count_q != FULL_CNT);
  assign rd_valid_o = (count_q != '0);

  assign push = wr_valid_i && wr_ready_o && !flush_i;
  assign pop  = rd_ready_i && rd_valid_o && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only and is deliberately left without reset.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/mips_imm_extender.sv
// ---------------------------------------------------------------------------
// mips_imm_extender
//   Extends a raw IN_W-bit immediate to OUT_W bits (sign, zero, upper, byte)
//   at the input and queues the result in a DEPTH-entry FIFO.
//
//   Ports
//     clk       : clock
//     rst       : asynchronous active-low reset
//     flush     : synchronous buffer clear, wins over push/pop
//     in_valid  : in_data/in_mode valid
//     in_ready  : an entry can be accepted this cycle
//     in_data   : raw immediate
//     in_mode   : extension mode (mips_pkg::ext_mode_e encoding)
//     out_valid : out_data holds the buffer head
//     out_ready : consumer accepts the head
//     out_data  : extended value at the head
//     count     : occupied entries
// ---------------------------------------------------------------------------
module mips_imm_extender
  import mips_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0] count
);

  logic [OUT_W-1:0] ext_result;

  // Only the extended word is stored; the raw immediate and mode are not kept.
  assign ext_result = OUT_W'(imm_extend({{(EXT_MAX_W-IN_W){1'b0}}, in_data},
                                        ext_mode_e'(in_mode), IN_W, OUT_W));

  mips_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .flush_i    (flush),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_data_i  (ext_result),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_data_o  (out_data),
    .count_o    (count)
  );

endmodule

// File: tb/tb_mips_imm_extender.sv
module tb_mips_imm_extender;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  count;

  int checks = 0;
  int passes = 0;

  mips_imm_extender #(.IN_W(16), .OUT_W(32), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [1:0] m, input logic [15:0] d);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] bp_exp [4];
  logic [31:0] q [$];
  int          pushed;
  int          cyc;
  logic        do_push, do_pop;
  logic [15:0] rd;
  logic [1:0]  rm;

  initial begin
    vecs[0] = '{2'd0, 16'h8000, 32'hFFFF8000};
    vecs[1] = '{2'd0, 16'h7FFF, 32'h00007FFF};
    vecs[2] = '{2'd1, 16'hFFFF, 32'h0000FFFF};
    vecs[3] = '{2'd2, 16'h1234, 32'h12340000};
    vecs[4] = '{2'd3, 16'h00FE, 32'hFFFFFFFE};
    vecs[5] = '{2'd1, 16'h8000, 32'h00008000};
    vecs[6] = '{2'd2, 16'hFFFF, 32'hFFFF0000};
    vecs[7] = '{2'd3, 16'h127F, 32'h0000007F};
    vecs[8] = '{2'd3, 16'hAB80, 32'hFFFFFF80};
    vecs[9] = '{2'd0, 16'h0000, 32'h00000000};
    bp_exp[0] = 32'h00000001;
    bp_exp[1] = 32'hFFFFFFFE;
    bp_exp[2] = 32'h00000000;
    bp_exp[3] = 32'hFFFFFFFF;

    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b0;

    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready",  in_ready,  1);
    chk("reset_count",     count,     0);

    // Release between edges; the next rising edge is the first usable one.
    #21 rst = 1'b1;

    // Table of modes, one push per cycle with out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(vecs[i].mode, vecs[i].data);
      chk($sformatf("mode_valid_%0d", i), out_valid, 1);
      chk($sformatf("mode_data_%0d", i),  out_data,  vecs[i].exp);
      chk($sformatf("mode_count_%0d", i), count,     1);
    end
    step();
    chk("mode_drain_count", count,     0);
    chk("mode_drain_valid", out_valid, 0);

    // Back-pressure: fill with out_ready low.
    out_ready = 1'b0;
    push_one(2'd0, 16'h0001);
    push_one(2'd0, 16'hFFFE);
    push_one(2'd0, 16'h0000);
    push_one(2'd0, 16'hFFFF);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_full_count",    count,    4);
    push_one(2'd0, 16'h1234);
    chk("bp_blocked_count", count,    4);
    chk("bp_hold_data",     out_data, 32'h00000001);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_drain_valid_%0d", k), out_valid, 1);
      chk($sformatf("bp_drain_data_%0d", k),  out_data,  bp_exp[k]);
      step();
    end
    chk("bp_empty_valid", out_valid, 0);
    chk("bp_empty_count", count,     0);

    // Full plus simultaneous pop: pop proceeds, push is blocked.
    out_ready = 1'b0;
    push_one(2'd1, 16'h0011);
    push_one(2'd1, 16'h0022);
    push_one(2'd1, 16'h0033);
    push_one(2'd1, 16'h0044);
    chk("fp_full_count", count, 4);
    out_ready = 1'b1;
    push_one(2'd1, 16'h0055);
    out_ready = 1'b0;
    chk("fp_count",    count,    3);
    chk("fp_head",     out_data, 32'h00000022);
    chk("fp_in_ready", in_ready, 1);

    // Flush with three entries and a competing push.
    flush = 1'b1;
    push_one(2'd1, 16'h0066);
    flush = 1'b0;
    chk("flush_count", count,     0);
    chk("flush_valid", out_valid, 0);
    step();
    chk("flush_dropped_count", count, 0);

    // Streaming with random traffic, scoreboarded against the package function.
    pushed = 0;
    cyc    = 0;
    while ((pushed < 20 || q.size() != 0) && cyc < 600) begin
      rd        = 16'($urandom());
      rm        = 2'($urandom());
      in_valid  = (pushed < 20) && ($urandom_range(0, 3) != 0);
      in_data   = rd;
      in_mode   = rm;
      out_ready = 1'($urandom_range(0, 1));
      do_push   = in_valid && in_ready;
      do_pop    = out_valid && out_ready;
      if (do_pop) begin
        if (q.size() == 0) chk("stream_spurious_pop", out_valid, 0);
        else begin
          chk($sformatf("stream_data_%0d", cyc), out_data, q[0]);
          void'(q.pop_front());
        end
      end
      if (do_push) begin
        q.push_back(32'(imm_extend({48'h0, rd}, ext_mode_e'(rm), 16, 32)));
        pushed++;
      end
      step();
      chk($sformatf("stream_count_%0d", cyc), count, q.size());
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("stream_completed", (pushed == 20) && (q.size() == 0), 1);

    // Asynchronous reset with two entries buffered.
    push_one(2'd0, 16'h0101);
    push_one(2'd0, 16'h0202);
    chk("rst_pre_count", count, 2);
    #3 rst = 1'b0;
    #1;
    chk("rst_async_valid",    out_valid, 0);
    chk("rst_async_count",    count,     0);
    chk("rst_async_in_ready", in_ready,  1);
    #1 rst = 1'b1;
    #1;
    chk("rst_release_valid", out_valid, 0);
    push_one(2'd2, 16'h8000);
    chk("rst_first_count", count,     1);
    chk("rst_first_valid", out_valid, 1);
    chk("rst_first_data",  out_data,  32'h80000000);
    out_ready = 1'b1;
    step();
    chk("rst_final_count", count, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
